axi_slave_rd_ctrl: RTL

AXI4 read-channel engine that sits between the AXI read interface (AR/R channels) and the simple slave memory port.
- Accepts one AR burst at a time.
- Expands the burst (FIXED/INCR/WRAP) into single-word reads on add_rd/oen.
- Captures dat_rd one cycle after oen and returns the beats on the R channel.
- R-channel backpressure is absorbed by a 2-entry credit-controlled buffer, so no memory read is ever lost.
- Drops in as the read half of the slave top-level.

---
 rtl/axi_slave_pkg.sv | 17 +
 rtl/axi_slave_rd_buf.sv | 67 ++++++
 rtl/axi_slave_rd_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/axi_slave_pkg.sv
// Shared AXI slave definitions: burst and response codes plus the read FSM encoding.
package axi_slave_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_DRAIN
  } rd_state_t;

endpackage

// File: rtl/axi_slave_rd_buf.sv
// Two-entry R-channel skid FIFO; the head entry is a register that drives the R outputs directly.
module axi_slave_rd_buf #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [1:0]            push_resp,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            head_resp,
  output logic                  head_last
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } entry_t;

  entry_t head, tail, din;

  assign din = {push_data, push_resp, push_last};

  // Head always holds the oldest beat; a pop shifts the tail forward so outputs stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          tail  <= '0;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign head_data = head.data;
  assign head_resp = head.resp;
  assign head_last = head.last;

endmodule

// File: rtl/axi_slave_rd_ctrl.sv
// AXI4 read engine: expands one AR burst into single-word memory reads and returns beats on R.
module axi_slave_rd_ctrl
  import axi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic [ID_WIDTH-1:0]   arid,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] dat_rd,
  output logic [ADDR_WIDTH-1:0] add_rd,
  output logic                  oen
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(1) << BYTE_SHIFT;
  localparam logic [ADDR_WIDTH-1:0] BYTE_MASK = STEP - ADDR_WIDTH'(1);

  rd_state_t             state, state_n;
  logic [ADDR_WIDTH-1:0] cur_addr, wrap_mask, next_addr, ar_wrap_mask;
  logic [7:0]            len, beat;
  logic [1:0]            burst;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  err, ar_err, ar_hs, ar_en;
  logic                  issue, issued_d, last_d, credit_ok, pop;
  logic [1:0]            buf_count;
  logic                  buf_full, buf_empty;

  assign arready = (state == RD_IDLE) && ar_en;
  assign ar_hs   = arvalid && arready;
  assign pop     = rvalid && rready;

  assign ar_wrap_mask = ((ADDR_WIDTH'(arlen) + ADDR_WIDTH'(1)) << BYTE_SHIFT) - ADDR_WIDTH'(1);
  assign ar_err = (arsize != 3'(BYTE_SHIFT)) || (arburst == 2'd3) ||
                  ((arburst == AXI_BURST_WRAP) &&
                   (!(arlen == 8'd1 || arlen == 8'd3 || arlen == 8'd7 || arlen == 8'd15) ||
                    ((araddr & BYTE_MASK) != '0)));

  // A read in flight counts as occupied so its data always has a slot waiting one cycle later.
  assign credit_ok = (3'(buf_count) + 3'(issued_d)) < (3'd2 + 3'(pop));

  always_comb begin
    next_addr = cur_addr + STEP;
    case (burst)
      AXI_BURST_FIXED: next_addr = cur_addr;
      AXI_BURST_INCR:  next_addr = cur_addr + STEP;
      AXI_BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + STEP) & wrap_mask);
      default:         next_addr = cur_addr + STEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      RD_IDLE:  if (ar_hs) state_n = RD_ISSUE;
      RD_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (beat == len) state_n = RD_DRAIN;
        end
      end
      RD_DRAIN: if (pop && rlast) state_n = RD_IDLE;
      default:  state_n = RD_IDLE;
    endcase
  end

  // ar_en keeps arready low for the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      wrap_mask <= '0;
      len       <= 8'd0;
      beat      <= 8'd0;
      burst     <= AXI_BURST_FIXED;
      err       <= 1'b0;
      id_q      <= '0;
      issued_d  <= 1'b0;
      last_d    <= 1'b0;
      ar_en     <= 1'b0;
    end else begin
      ar_en    <= 1'b1;
      issued_d <= issue;
      last_d   <= issue && (beat == len);
      if (ar_hs) begin
        cur_addr  <= araddr;
        wrap_mask <= ar_wrap_mask;
        len       <= arlen;
        beat      <= 8'd0;
        burst     <= arburst;
        err       <= ar_err;
        id_q      <= arid;
      end else if (issue) begin
        cur_addr <= next_addr;
        beat     <= beat + 8'd1;
      end
    end
  end

  assign oen    = issue && !err;
  assign add_rd = cur_addr >> BYTE_SHIFT;
  assign rid    = id_q;
  assign rvalid = !buf_empty;

  axi_slave_rd_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (issued_d),
    .push_data (err ? '0 : dat_rd),
    .push_resp (err ? AXI_RESP_SLVERR : AXI_RESP_OKAY),
    .push_last (last_d),
    .pop       (pop),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty),
    .head_data (rdata),
    .head_resp (rresp),
    .head_last (rlast)
  );

  assert property (@(posedge clk) disable iff (rst) !(buf_full && issued_d && !pop));

endmodule
